// File: rtl/mul_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU retire in one cycle as no-ops.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     operand_q, operand_d;
  logic                 isDiv_q, isDiv_d;
  logic                 negA_q, negA_d;
  logic                 negB_q, negB_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 divByZero_q, divByZero_d;

  logic                 signedOp;
  logic [WIDTH-1:0]     magA, magB;
  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   mulNext;
  logic [2*WIDTH-1:0]   product;

  assign signedOp = ~op[0];
  assign magA     = (signedOp && operandA[WIDTH-1]) ? -operandA : operandA;
  assign magB     = (signedOp && operandB[WIDTH-1]) ? -operandB : operandB;

  // acc holds {partial product, remaining multiplier bits}.
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
  assign mulNext = {mulSum, acc_q[WIDTH-1:1]};
  assign product = (negA_q ^ negB_q) ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  logic                 divZero_q, divZero_d;
  logic [WIDTH:0]       divShift, divDiff;
  logic [2*WIDTH-1:0]   divNext;
  logic [WIDTH-1:0]     quo, rem;

  // acc holds {remainder, dividend bits being shifted out / quotient bits shifted in}.
  assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, operand_q};
  assign divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    operand_d   = operand_q;
    isDiv_d     = isDiv_q;
    negA_d      = negA_q;
    negB_d      = negB_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    divByZero_d = 1'b0;
`ifdef MULDIV_DIV_EN
    divZero_d   = divZero_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          isDiv_d = op[1];
          negA_d  = signedOp & operandA[WIDTH-1];
          negB_d  = signedOp & operandB[WIDTH-1];
          count_d = '0;
          if (op[1]) begin
`ifdef MULDIV_DIV_EN
            divZero_d = (operandB == '0);
            acc_d     = {{WIDTH{1'b0}}, magA};
            operand_d = magB;
            state_d   = StRun;
`else
            state_d   = StFix;
`endif
          end else begin
            acc_d     = {{WIDTH{1'b0}}, magB};
            operand_d = magA;
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
`ifdef MULDIV_DIV_EN
          acc_d = isDiv_q ? divNext : mulNext;
`else
          acc_d = mulNext;
`endif
          count_d = count_q + 1'b1;
          if (count_q == CntW'(WIDTH - 1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (!isDiv_q) begin
            hi_d = product[2*WIDTH-1:WIDTH];
            lo_d = product[WIDTH-1:0];
          end else begin
`ifdef MULDIV_DIV_EN
            // With a zero divisor the remainder ends up equal to |dividend|, so the
            // sign fix below restores operandA in hi. MIN/-1 also falls out naturally.
            lo_d        = divZero_q ? '1 : ((negA_q ^ negB_q) ? -quo : quo);
            hi_d        = negA_q ? -rem : rem;
            divByZero_d = divZero_q;
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      acc_q       <= '0;
      operand_q   <= '0;
      isDiv_q     <= 1'b0;
      negA_q      <= 1'b0;
      negB_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      divByZero_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      divZero_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      operand_q   <= operand_d;
      isDiv_q     <= isDiv_d;
      negA_q      <= negA_d;
      negB_q      <= negB_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
      divByZero_q <= divByZero_d;
`ifdef MULDIV_DIV_EN
      divZero_q   <= divZero_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign divByZero = divByZero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32) against a 64-bit arithmetic reference model.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        flush = 1'b0;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] Min = 32'h8000_0000;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .operandA(operandA),
    .operandB(operandB), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .divByZero(divByZero)
  );

  always #5 clock = ~clock;

  // Returns {divByZero, hi, lo} straight from the arithmetic definition of each op.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      2'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return {1'b0, p}; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == Min && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, Min};
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corner [4];
    corner = '{32'd0, 32'd1, Min, 32'hFFFF_FFFF};
    if ($urandom_range(0, 5) == 0) return corner[$urandom_range(0, 3)];
    return $urandom();
  endfunction

  // Launch one op now and wait (bounded) for done; reports what was seen, no checking.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, b, output int lat,
                       output logic [31:0] h, l, output logic dz, output logic gap,
                       output logic bd);
    op = o; operandA = a; operandB = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    gap = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) gap = 1'b1;
      @(posedge clock); #1;
      lat++;
    end
    h = hi; l = lo; dz = divByZero; bd = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    checks++; if (divByZero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", divByZero); end
    reset = 1'b0;
  endtask

  task automatic test_mult_directed();
    int lat; logic [31:0] h, l; logic dz, gap, bd;
    issue(2'd0, 32'hFFFF_FFFD, 32'd7, lat, h, l, dz, gap, bd);
    checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency got %0d want 33", lat); end
    checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi got %h want ffffffff", h); end
    checks++; if (l !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg_lo got %h want ffffffeb", l); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done got %b want 0", bd); end
    checks++; if (gap !== 1'b0) begin errors++; $display("FAIL mult_busy_gap got %b want 0", gap); end
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, h, l, dz, gap, bd);
    checks++; if (h !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi got %h want fffffffe", h); end
    checks++; if (l !== 32'h0000_0001) begin errors++; $display("FAIL multu_max_lo got %h want 1", l); end
    // Started in the done cycle of the previous op.
    issue(2'd0, 32'd2, 32'd3, lat, h, l, dz, gap, bd);
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    checks++; if (h !== 32'd0 || l !== 32'd6) begin errors++; $display("FAIL b2b_result got %h_%h want 0_6", h, l); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_mult_random();
    int lat; logic [31:0] h, l, a, b; logic dz, gap, bd; logic [1:0] o; logic [64:0] exp;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 1));
      a = pick(); b = pick();
      exp = model(o, a, b);
      issue(o, a, b, lat, h, l, dz, gap, bd);
      checks++;
      if (lat != 33 || {dz, h, l} !== exp)
        begin errors++; $display("FAIL mult_rand op=%0d a=%h b=%h got lat=%0d %b_%h_%h want lat=33 %b_%h_%h",
                                  o, a, b, lat, dz, h, l, exp[64], exp[63:32], exp[31:0]); end
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div_directed();
    int lat; logic [31:0] h, l; logic dz, gap, bd;
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, lat, h, l, dz, gap, bd);
    checks++; if (lat != 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
    checks++; if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_2 got %h_%h want ffffffff_fffffffd", h, l); end
    issue(2'd2, Min, 32'hFFFF_FFFF, lat, h, l, dz, gap, bd);
    checks++; if (l !== Min || h !== 32'd0 || dz !== 1'b0) begin errors++; $display("FAIL div_overflow got %b_%h_%h want 0_00000000_80000000", dz, h, l); end
    issue(2'd3, 32'd10, 32'd0, lat, h, l, dz, gap, bd);
    checks++; if (lat != 33) begin errors++; $display("FAIL divz_latency got %0d want 33", lat); end
    checks++; if (l !== 32'hFFFF_FFFF || h !== 32'd10 || dz !== 1'b1) begin errors++; $display("FAIL divu_zero got %b_%h_%h want 1_0000000a_ffffffff", dz, h, l); end
    @(posedge clock); #1;
    checks++; if (divByZero !== 1'b0) begin errors++; $display("FAIL dz_one_cycle got %b want 0", divByZero); end
    issue(2'd2, 32'hFFFF_FFF9, 32'd0, lat, h, l, dz, gap, bd);
    checks++; if (l !== 32'hFFFF_FFFF || h !== 32'hFFFF_FFF9 || dz !== 1'b1) begin errors++; $display("FAIL div_zero got %b_%h_%h want 1_fffffff9_ffffffff", dz, h, l); end
  endtask

  task automatic test_div_random();
    int lat; logic [31:0] h, l, a, b; logic dz, gap, bd; logic [1:0] o; logic [64:0] exp;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(2, 3));
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : pick());
      exp = model(o, a, b);
      issue(o, a, b, lat, h, l, dz, gap, bd);
      checks++;
      if (lat != 33 || {dz, h, l} !== exp)
        begin errors++; $display("FAIL div_rand op=%0d a=%h b=%h got lat=%0d %b_%h_%h want lat=33 %b_%h_%h",
                                  o, a, b, lat, dz, h, l, exp[64], exp[63:32], exp[31:0]); end
    end
  endtask
`else
  task automatic test_div_disabled();
    int lat; logic [31:0] h, l; logic dz, gap, bd;
    issue(2'd1, 32'd9, 32'd8, lat, h, l, dz, gap, bd);
    issue(2'd3, 32'd10, 32'd3, lat, h, l, dz, gap, bd);
    checks++; if (lat != 1) begin errors++; $display("FAIL nodiv_latency got %0d want 1", lat); end
    checks++; if (gap !== 1'b0) begin errors++; $display("FAIL nodiv_busy got gap=%b want 0", gap); end
    checks++; if (h !== 32'd0 || l !== 32'd72 || dz !== 1'b0) begin errors++; $display("FAIL nodiv_hold got %b_%h_%h want 0_00000000_00000048", dz, h, l); end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL nodiv_after got busy=%b done=%b want 0 0", busy, done); end
  endtask
`endif

  task automatic test_flush();
    int lat; logic [31:0] h, l; logic dz, gap, bd; logic sawDone;
    // 0xD4D5 * 0x663D81 = 0x55 * (2^32 + 1)
    issue(2'd1, 32'h0000_D4D5, 32'h0066_3D81, lat, h, l, dz, gap, bd);
    checks++; if (h !== 32'h55 || l !== 32'h55) begin errors++; $display("FAIL flush_preset got %h_%h want 55_55", h, l); end
    op = 2'd0; operandA = 32'd123; operandB = 32'd456; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_run_busy got %b want 0", busy); end
    sawDone = 1'b0;
    repeat (40) begin if (done === 1'b1) sawDone = 1'b1; @(posedge clock); #1; end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("FAIL flush_run_done got %b want 0", sawDone); end
    checks++; if (hi !== 32'h55 || lo !== 32'h55) begin errors++; $display("FAIL flush_run_hilo got %h_%h want 55_55", hi, lo); end
    // Flush arriving while the unit sits in the final fix-up cycle.
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (32) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_fix got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (hi !== 32'h55 || lo !== 32'h55) begin errors++; $display("FAIL flush_fix_hilo got %h_%h want 55_55", hi, lo); end
    start = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_idle got busy=%b want 0", busy); end
    sawDone = 1'b0;
    repeat (40) begin if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1; @(posedge clock); #1; end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("FAIL start_flush_launch got %b want 0", sawDone); end
  endtask

  task automatic test_start_while_busy();
    int lat; logic [64:0] exp;
    exp = model(2'd0, 32'hFFFF_FF00, 32'd1000);
    op = 2'd0; operandA = 32'hFFFF_FF00; operandB = 32'd1000; start = 1'b1;
    @(posedge clock); #1;
    op = 2'd1; operandA = 32'h1234_5678; operandB = 32'h9ABC_DEF0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clock); #1; lat++; end
    start = 1'b0;
    checks++; if (lat != 33) begin errors++; $display("FAIL held_start_latency got %0d want 33", lat); end
    checks++; if ({divByZero, hi, lo} !== exp) begin errors++; $display("FAIL held_start_result got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_start_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_op();
`ifdef MULDIV_DIV_EN
    op = 2'd2;
`else
    op = 2'd0;
`endif
    operandA = 32'hFFFF_FFF9; operandB = 32'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || divByZero !== 1'b0)
      begin errors++; $display("FAIL reset_mid_op got busy=%b done=%b hi=%h lo=%h dz=%b want all 0", busy, done, hi, lo, divByZero); end
  endtask

  initial begin
    test_reset();
    @(posedge clock); #1;
    test_mult_directed();
    test_mult_random();
`ifdef MULDIV_DIV_EN
    test_div_directed();
    test_div_random();
`else
    test_div_disabled();
`endif
    test_flush();
    test_start_while_busy();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
